dot11_tx_framer: RTL

//  Transmit-side counterpart of the dot11 receive byte path: frames one legacy PSDU for the

---
 rtl/dot11_tx_framer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/dot11_tx_framer.sv
// dot11_tx_framer
//   Frames one legacy PSDU for the OFDM TX chain. It emits the 24-bit SIGNAL
//   field as 3 bytes, then passes the MAC payload through, then appends the
//   4-byte CRC-32 FCS (reflected 0xEDB88320, init all-ones, final inversion).
//
// Ports
//   s00_axi_aclk     clock
//   s00_axi_aresetn  synchronous reset, active-low
//   pkt_start        1-cycle request; samples pkt_rate / pkt_len
//   pkt_rate[3:0]    SIGNAL rate bits (bit 3 must be set)
//   pkt_len          PSDU length in bytes including FCS (>= 5)
//   busy             high from accepted start through the done cycle
//   start_err        1-cycle pulse when a start request is rejected
//   byte_in*         payload byte stream from the TX buffer (valid/ready)
//   byte_out*        framed byte stream to the scrambler (valid/ready)
//   byte_out_is_sig  marks byte_out as a SIGNAL byte
//   tx_done          1-cycle pulse after the last FCS byte transfers
module dot11_tx_framer #(
  parameter int LEN_WIDTH = 12
) (
  input  logic                 s00_axi_aclk,
  input  logic                 s00_axi_aresetn,
  input  logic                 pkt_start,
  input  logic [3:0]           pkt_rate,
  input  logic [LEN_WIDTH-1:0] pkt_len,
  output logic                 busy,
  output logic                 start_err,
  input  logic [7:0]           byte_in,
  input  logic                 byte_in_valid,
  output logic                 byte_in_ready,
  output logic [7:0]           byte_out,
  output logic                 byte_out_valid,
  input  logic                 byte_out_ready,
  output logic                 byte_out_is_sig,
  output logic                 tx_done
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SIG     = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_FCS     = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;

  logic [2:0]           state;
  logic [23:0]          sig_word;
  logic [1:0]           sig_idx;
  logic [2:0]           fcs_idx;
  logic [LEN_WIDTH-1:0] remaining;
  logic [31:0]          crc;

  // output register stage
  logic [7:0]           data_p1;
  logic                 vld_p1;
  logic                 is_sig_p1;

  logic                 busy_r;
  logic                 start_err_r;
  logic                 tx_done_r;

  logic                 ld;
  logic                 in_xfer;
  logic                 start_ok;
  logic [23:0]          sig_new;
  logic [31:0]          fcs_word;

  function automatic logic [23:0] build_sig(input logic [3:0]           rate,
                                            input logic [LEN_WIDTH-1:0] len);
    logic [23:0] s;
    s        = '0;
    s[3:0]   = rate;
    s[16:5]  = 12'(len);
    s[17]    = ^s[16:0];
    return s;
  endfunction

  // One byte of the LSB-first reflected CRC-32.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c_in,
                                             input logic [7:0]  d);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ CRC_POLY;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // The output slot can take a new byte when empty or draining this cycle.
  assign ld            = ~vld_p1 | byte_out_ready;
  assign byte_in_ready = (state == ST_PAYLOAD) & ld & (remaining != '0);
  assign in_xfer       = byte_in_valid & byte_in_ready;
  assign start_ok      = pkt_rate[3] & (pkt_len >= LEN_WIDTH'(5));
  assign sig_new       = build_sig(pkt_rate, pkt_len);
  assign fcs_word      = ~crc;

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      state       <= ST_IDLE;
      sig_word    <= '0;
      sig_idx     <= '0;
      fcs_idx     <= '0;
      remaining   <= '0;
      crc         <= CRC_INIT;
      data_p1     <= '0;
      vld_p1      <= 1'b0;
      is_sig_p1   <= 1'b0;
      busy_r      <= 1'b0;
      start_err_r <= 1'b0;
      tx_done_r   <= 1'b0;
    end else begin
      start_err_r <= 1'b0;
      tx_done_r   <= 1'b0;
      // A transferred byte leaves the slot empty unless a new one is loaded below.
      if (ld) vld_p1 <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (pkt_start) begin
            if (start_ok) begin
              // First SIGNAL byte goes straight into the output register so it
              // is valid the cycle after the start request.
              sig_word  <= sig_new;
              remaining <= pkt_len - LEN_WIDTH'(4);
              busy_r    <= 1'b1;
              data_p1   <= sig_new[7:0];
              is_sig_p1 <= 1'b1;
              vld_p1    <= 1'b1;
              sig_idx   <= 2'd1;
              state     <= ST_SIG;
            end else begin
              start_err_r <= 1'b1;
            end
          end
        end

        ST_SIG: begin
          if (ld) begin
            data_p1   <= sig_word[{sig_idx, 3'b000} +: 8];
            is_sig_p1 <= 1'b1;
            vld_p1    <= 1'b1;
            if (sig_idx == 2'd2) state <= ST_PAYLOAD;
            else                 sig_idx <= sig_idx + 2'd1;
          end
        end

        ST_PAYLOAD: begin
          if (in_xfer) begin
            data_p1   <= byte_in;
            is_sig_p1 <= 1'b0;
            vld_p1    <= 1'b1;
            crc       <= crc32_byte(crc, byte_in);
            remaining <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) begin
              fcs_idx <= '0;
              state   <= ST_FCS;
            end
          end
        end

        ST_FCS: begin
          if (ld) begin
            // fcs_idx==4: all four bytes loaded and the last one is transferring now.
            if (fcs_idx == 3'd4) begin
              tx_done_r <= 1'b1;
              state     <= ST_DONE;
            end else begin
              data_p1   <= fcs_word[{fcs_idx[1:0], 3'b000} +: 8];
              is_sig_p1 <= 1'b0;
              vld_p1    <= 1'b1;
              fcs_idx   <= fcs_idx + 3'd1;
            end
          end
        end

        ST_DONE: begin
          busy_r <= 1'b0;
          crc    <= CRC_INIT;
          state  <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign byte_out        = data_p1;
  assign byte_out_valid  = vld_p1;
  assign byte_out_is_sig = is_sig_p1;
  assign busy            = busy_r;
  assign start_err       = start_err_r;
  assign tx_done         = tx_done_r;

endmodule
